// File: rtl/strobe_pulse_generator_if.sv
// Signal bundle between the trigger decoder (master) and the strobe pulse generator (slave).
// Carries trigger/programming inputs and the pulse/status outputs.
interface strobe_pulse_generator_if #(
  parameter int DELAY_W    = 3,
  parameter int DURATION_W = 16,
  parameter int CNT_W      = 8
);
  logic                  enable;
  logic                  trigger_in;
  logic [DELAY_W-1:0]    delay;
  logic [DURATION_W-1:0] duration;
  logic                  pulse_out;
  logic                  busy;
  logic                  trigger_dropped;
  logic [CNT_W-1:0]      dropped_count;

  modport master (
    output enable, trigger_in, delay, duration,
    input  pulse_out, busy, trigger_dropped, dropped_count
  );

  modport slave (
    input  enable, trigger_in, delay, duration,
    output pulse_out, busy, trigger_dropped, dropped_count
  );
endinterface

// File: rtl/strobe_pulse_generator.sv
// Single-pulse engine: each accepted rising edge of trigger_in yields one pulse after a
// programmable delay, lasting a programmable number of cycles; edges seen while busy are counted.
module strobe_pulse_generator #(
  parameter int DELAY_W    = 3,
  parameter int DURATION_W = 16,
  parameter int CNT_W      = 8
) (
  input logic                    clk,
  input logic                    rst,
  strobe_pulse_generator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t                state;
  logic                  trig_q;
  logic [DELAY_W-1:0]    delay_cnt;
  logic [DURATION_W-1:0] width_cnt;
  logic                  pulse_q;
  logic                  busy_q;
  logic                  drop_q;
  logic [CNT_W-1:0]      drop_cnt_q;
  logic                  rise;

  assign rise = bus.trigger_in & ~trig_q;

  // NOTE: every register here uses <= so all updates see the pre-edge values of their peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      trig_q     <= 1'b1;  // a trigger held high across reset must not look like a fresh edge
      delay_cnt  <= '0;
      width_cnt  <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      trig_q <= bus.trigger_in;
      drop_q <= 1'b0;

      case (state)
        IDLE: begin
          if (rise && bus.enable && (bus.duration != '0)) begin
            // width_cnt doubles as the latched duration while the delay runs out
            width_cnt <= bus.duration - DURATION_W'(1);
            busy_q    <= 1'b1;
            if (bus.delay <= DELAY_W'(1)) begin
              state   <= ACTIVE;
              pulse_q <= 1'b1;
            end else begin
              state     <= DELAY;
              delay_cnt <= bus.delay - DELAY_W'(2);
            end
          end
        end

        DELAY: begin
          if (delay_cnt == '0) begin
            state   <= ACTIVE;
            pulse_q <= 1'b1;
          end else begin
            delay_cnt <= delay_cnt - DELAY_W'(1);
          end
        end

        ACTIVE: begin
          if (width_cnt == '0) begin
            state   <= IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            width_cnt <= width_cnt - DURATION_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase

      if (rise && bus.enable && (state != IDLE)) begin
        drop_q <= 1'b1;
        if (drop_cnt_q != '1)
          drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pulse_out       = pulse_q;
  assign bus.busy            = busy_q;
  assign bus.trigger_dropped = drop_q;
  assign bus.dropped_count   = drop_cnt_q;

endmodule

// File: tb/tb_strobe_pulse_generator.sv
// Scoreboard bench: a time-window reference model predicts each cycle's outputs;
// a separate monitor compares them against the DUT one cycle after each drive.
module tb_strobe_pulse_generator;

  localparam int DW      = 3;
  localparam int LW      = 16;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  strobe_pulse_generator_if #(.DELAY_W(DW), .DURATION_W(LW), .CNT_W(CW)) bus ();

  strobe_pulse_generator #(.DELAY_W(DW), .DURATION_W(LW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          pulse;
    logic          busy;
    logic          drop;
    logic [CW-1:0] cnt;
  } resp_t;

  resp_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  string phase = "reset";

  // Reference model: one accepted pulse described by its start edge t0, delay d and length l.
  int n     = 0;
  bit hist  = 1'b1;
  bit have  = 1'b0;
  int t0    = 0;
  int d     = 1;
  int l     = 1;
  int cnt   = 0;

  task automatic check(input string name, input resp_t act, input resp_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got pulse=%0b busy=%0b drop=%0b cnt=%0d, expected pulse=%0b busy=%0b drop=%0b cnt=%0d",
               name, $time, act.pulse, act.busy, act.drop, act.cnt,
               exp.pulse, exp.busy, exp.drop, exp.cnt);
    end
  endtask

  task automatic step(input bit r, input bit en, input bit trig, input int dly, input int dur);
    bit    drop;
    bit    busy_now;
    int    m;
    resp_t e;
    @(negedge clk);
    rst            = r;
    bus.enable     = en;
    bus.trigger_in = trig;
    bus.delay      = dly[DW-1:0];
    bus.duration   = dur[LW-1:0];

    drop     = 1'b0;
    busy_now = have && (n < t0 + d + l);
    if (r) begin
      hist = 1'b1;
      have = 1'b0;
      cnt  = 0;
    end else begin
      if (trig && !hist && en) begin
        if (busy_now) begin
          drop = 1'b1;
          if (cnt < CNT_MAX) cnt++;
        end else if (dur != 0) begin
          have = 1'b1;
          t0   = n;
          d    = (dly == 0) ? 1 : dly;
          l    = dur;
        end
      end
      hist = trig;
    end

    m       = n + 1;
    e.pulse = have && (m >= t0 + d) && (m < t0 + d + l);
    e.busy  = have && (m > t0) && (m < t0 + d + l);
    e.drop  = drop;
    e.cnt   = CW'(cnt);
    exp_q.push_back(e);
    n++;
  endtask

  task automatic run(input int cycles, input bit en, input bit trig, input int dly, input int dur);
    for (int i = 0; i < cycles; i++) step(1'b0, en, trig, dly, dur);
  endtask

  initial begin : monitor
    resp_t e;
    resp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.pulse_out, bus.busy, bus.trigger_dropped, bus.dropped_count};
        check(phase, a, e);
      end
    end
  end

  initial begin : stimulus
    bus.enable     = 1'b0;
    bus.trigger_in = 1'b0;
    bus.delay      = '0;
    bus.duration   = '0;

    phase = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0, 0);
    run(3, 1'b1, 1'b0, 0, 0);

    phase = "d3_l5";
    run(1, 1'b1, 1'b1, 3, 5);
    run(11, 1'b1, 1'b1, 3, 5);
    run(2, 1'b1, 1'b0, 3, 5);

    phase = "d0_l1";
    run(1, 1'b1, 1'b1, 0, 1);
    run(4, 1'b1, 1'b0, 0, 1);

    phase = "dur0";
    run(1, 1'b1, 1'b1, 2, 0);
    run(4, 1'b1, 1'b0, 2, 0);

    phase = "enable0";
    run(1, 1'b0, 1'b1, 2, 3);
    run(4, 1'b0, 1'b0, 2, 3);

    phase = "drop_active";
    run(1, 1'b1, 1'b1, 2, 10);
    run(3, 1'b1, 1'b0, 2, 10);
    run(2, 1'b1, 1'b0, 2, 10);
    run(1, 1'b1, 1'b1, 2, 10);
    run(8, 1'b1, 1'b0, 2, 10);

    phase = "saturate";
    run(1, 1'b1, 1'b1, 1, 30);
    for (int i = 0; i < 5; i++) begin
      run(1, 1'b1, 1'b0, 1, 30);
      run(1, 1'b1, 1'b1, 1, 30);
    end
    run(25, 1'b1, 1'b0, 1, 30);

    phase = "rst_mid";
    run(1, 1'b1, 1'b1, 1, 8);
    run(3, 1'b1, 1'b1, 1, 8);
    step(1'b1, 1'b1, 1'b1, 1, 8);
    run(10, 1'b1, 1'b1, 1, 8);
    run(1, 1'b1, 1'b0, 1, 8);
    run(1, 1'b1, 1'b1, 1, 8);
    run(10, 1'b1, 1'b0, 1, 8);

    phase = "latch";
    run(1, 1'b1, 1'b1, 7, 4);
    for (int i = 0; i < 12; i++) run(1, 1'b1, 1'b1, $urandom_range(0, 7), $urandom_range(0, 20));
    run(2, 1'b1, 1'b0, 0, 0);

    phase = "max_delay";
    run(1, 1'b1, 1'b1, 7, 300);
    run(310, 1'b1, 1'b0, 7, 300);

    phase = "back_to_back";
    for (int i = 0; i < 24; i++) run(1, 1'b1, i[0], 1, 3);

    phase = "random";
    begin
      bit trig;
      trig = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 2) == 0) trig = ~trig;
        step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), trig,
             $urandom_range(0, 7), $urandom_range(0, 9));
      end
    end

    phase = "drain";
    run(20, 1'b1, 1'b0, 0, 0);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
